compress_threshold_ctrl: RTL and testbench
==========================================

Name: compress_threshold_ctrl

Overview:
Frame-synchronised calibration sequencer and compressor for the marker-detect colour path. At the start of each enabled frame it measures the per-channel mean over the first CALIB_PIXELS pixels. It then clamps that mean and freezes it as the per-channel threshold for the rest of the frame and the start of the next one. Every accepted pixel is compressed to a 3-bit code against the thresholds currently held. The block sits between the camera pixel stream (valid/ready) and the marker detector.

Parameters:
COLOUR_DEPTH, 8, bits per colour channel
CALIB_PIXELS, 1024, pixels averaged per calibration; power of two, >= 2
MIN_THRES, 50, lower clamp on a calibrated threshold
MAX_THRES, 200, upper clamp on a calibrated threshold
DEFAULT_THRES, 128, threshold used after reset for all channels; MIN_THRES <= DEFAULT_THRES <= MAX_THRES < 2**COLOUR_DEPTH

Ports:
clk_in  in  1  clock; single clock domain
rst_n_in  in  1  reset, asynchronous, active-low
rgb_in  in  3*COLOUR_DEPTH  pixel {blue, green, red}; red in the LSBs
pix_valid_in  in  1  rgb_in/sof_in valid
pix_ready_out  out  1  block can accept a pixel
sof_in  in  1  first pixel of frame; qualified by pix_valid_in
cfg_enable_in  in  1  calibration/compression enable; sampled only on an accepted sof pixel
compressed_out  out  3  bit0 red, bit1 green, bit2 blue; 1 = channel > threshold
comp_valid_out  out  1  compressed_out valid
comp_ready_in  in  1  downstream accepts compressed_out
thres_out  out  3*COLOUR_DEPTH  current thresholds {blue, green, red}
calib_done_out  out  1  one-cycle pulse: new thresholds latched

Behaviour:
- Accept = pix_valid_in && pix_ready_out. pix_ready_out = !comp_valid_out || comp_ready_in (combinational) in every state.
- Output register, latency 1:
  - On accept in CALIB or RUN: comp_valid_out <= 1. compressed_out <= strict per-channel compare of rgb_in against the thresholds held before this edge.
  - Otherwise, if comp_ready_in: comp_valid_out <= 0.
  - compressed_out holds while comp_valid_out && !comp_ready_in.
- FSM states: IDLE, CALIB, RUN.
  - IDLE: accepted pixels are dropped; no output is produced. Accepted sof with cfg_enable_in=1 -> CALIB. That pixel is calibration pixel 0 and is also output.
  - CALIB: each accepted pixel is added to the per-channel sums and the counter increments.
    - Pixel number CALIB_PIXELS-1 accepted without sof:
      - thres[c] <= clamp((sum[c] + pixel[c]) >> log2(CALIB_PIXELS)).
      - state -> RUN, counter <= 0, sums <= 0.
      - calib_done_out = 1 on the following cycle only.
    - Accepted sof mid-CALIB (short frame): calibration restarts with that pixel as pixel 0, thresholds unchanged, no calib_done pulse. If cfg_enable_in=0 on that pixel, go to IDLE and drop the pixel.
  - RUN: output only. Accepted sof with cfg_enable_in=1 -> CALIB, sums seeded with that pixel, counter = 1. Accepted sof with cfg_enable_in=0 -> IDLE, pixel dropped.
  - cfg_enable_in has no effect except on accepted sof pixels.
- Arithmetic:
  - Accumulators are COLOUR_DEPTH + log2(CALIB_PIXELS) bits wide and cannot overflow.
  - Mean is truncated.
  - clamp(x) = MIN_THRES if x < MIN_THRES; MAX_THRES if x > MAX_THRES; else x.
  - Compare is strict >: a channel equal to its threshold gives 0.
- Thresholds persist across IDLE and across frames until the next completed calibration.
- Reset, asynchronous: state IDLE, thresholds = DEFAULT_THRES, sums 0, counter 0, comp_valid_out 0, compressed_out 0, calib_done_out 0. Reset mid-CALIB discards the partial sums.

Test Plan:
- Reset asserted mid-stream -> immediately comp_valid_out=0, compressed_out=0, calib_done_out=0, thres_out = {128,128,128}.
- CALIB_PIXELS=4, enable=1:
  - Pixels (r,g,b) = (100,30,220) x4, first with sof -> codes 3'b100 x4; thres_out -> r=100, g=50, b=200; one calib_done pulse.
  - Next pixels (101,60,201) -> 3'b111 and (100,50,200) -> 3'b000.
- Backpressure: comp_ready_in=0 for 3 cycles with pix_valid_in=1 -> pix_ready_out=0, compressed_out/comp_valid_out stable, calibration count unchanged. On release, the next pixel is output one cycle after accept.
- Short frame: sof arrives after 2 CALIB pixels -> thresholds unchanged, no calib_done. Calibration completes 4 pixels after the new sof.
- sof with enable=0 in RUN -> IDLE, no further comp_valid_out, thresholds retained. Later sof with enable=1 -> CALIB; that pixel is output using the retained thresholds.
- Clamp bounds: calibrate on (10,250,200) -> thresholds (50,200,200). Pixel (50,201,200) -> 3'b010.

Source files
------------

// File: rtl/compress_threshold_ctrl_if.sv
// Pixel-in / code-out stream bundle for compress_threshold_ctrl.
// slave is the block's view; master is the camera/detector side.
interface compress_threshold_ctrl_if #(
    parameter int COLOUR_DEPTH = 8
);
    logic [3*COLOUR_DEPTH-1:0] rgb_in;
    logic                      pix_valid_in;
    logic                      pix_ready_out;
    logic                      sof_in;
    logic                      cfg_enable_in;
    logic [2:0]                compressed_out;
    logic                      comp_valid_out;
    logic                      comp_ready_in;

    modport slave (
        input  rgb_in, pix_valid_in, sof_in, cfg_enable_in, comp_ready_in,
        output pix_ready_out, compressed_out, comp_valid_out
    );

    modport master (
        output rgb_in, pix_valid_in, sof_in, cfg_enable_in, comp_ready_in,
        input  pix_ready_out, compressed_out, comp_valid_out
    );
endinterface

// File: rtl/compress_threshold_ctrl.sv
// Frame-synchronised threshold calibration and 3-bit colour compression.
// One compress_threshold_chan per colour channel holds that channel's sum and threshold.
module compress_threshold_chan #(
    parameter int COLOUR_DEPTH  = 8,
    parameter int LOG2_PIX      = 10,
    parameter int MIN_THRES     = 50,
    parameter int MAX_THRES     = 200,
    parameter int DEFAULT_THRES = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [COLOUR_DEPTH-1:0] pix_i,
    input  logic                    seed_i,
    input  logic                    add_i,
    input  logic                    latch_i,
    input  logic                    clr_i,
    output logic [COLOUR_DEPTH-1:0] thres_o,
    output logic                    gt_o
);
    localparam int ACC_W = COLOUR_DEPTH + LOG2_PIX;
    localparam logic [COLOUR_DEPTH-1:0] MIN_V = COLOUR_DEPTH'(MIN_THRES);
    localparam logic [COLOUR_DEPTH-1:0] MAX_V = COLOUR_DEPTH'(MAX_THRES);
    localparam logic [COLOUR_DEPTH-1:0] DEF_V = COLOUR_DEPTH'(DEFAULT_THRES);

    logic [ACC_W-1:0]        sum_q, sum_d, acc;
    logic [COLOUR_DEPTH-1:0] thres_q, thres_d, mean;

    // Sum plus the closing pixel; the top bits are the truncated mean.
    assign acc  = sum_q + ACC_W'(pix_i);
    assign mean = acc[ACC_W-1:LOG2_PIX];

    always_comb begin
        sum_d   = sum_q;
        thres_d = thres_q;
        if (latch_i) begin
            sum_d = '0;
            if (mean < MIN_V)      thres_d = MIN_V;
            else if (mean > MAX_V) thres_d = MAX_V;
            else                   thres_d = mean;
        end else if (seed_i) begin
            sum_d = ACC_W'(pix_i);
        end else if (add_i) begin
            sum_d = acc;
        end else if (clr_i) begin
            sum_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_q   <= '0;
            thres_q <= DEF_V;
        end else begin
            sum_q   <= sum_d;
            thres_q <= thres_d;
        end
    end

    assign thres_o = thres_q;
    assign gt_o    = pix_i > thres_q;
endmodule

module compress_threshold_ctrl #(
    parameter int COLOUR_DEPTH  = 8,
    parameter int CALIB_PIXELS  = 1024,
    parameter int MIN_THRES     = 50,
    parameter int MAX_THRES     = 200,
    parameter int DEFAULT_THRES = 128
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    compress_threshold_ctrl_if.slave    px,
    output logic [3*COLOUR_DEPTH-1:0]   thres_out,
    output logic                        calib_done_out
);
    localparam int LOG2_PIX = $clog2(CALIB_PIXELS);
    localparam logic [LOG2_PIX-1:0] LAST_PIX = LOG2_PIX'(CALIB_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, CALIB, RUN} state_t;

    state_t              state_q, state_d;
    logic [LOG2_PIX-1:0] cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [2:0]          code_q, code_d;
    logic                done_q, done_d;
    logic                pix_ready, accept, emit;
    logic                seed, add, latch, clr;
    logic [2:0]          gt;

    genvar c;
    generate
        for (c = 0; c < 3; c++) begin : g_chan
            compress_threshold_chan #(
                .COLOUR_DEPTH (COLOUR_DEPTH),
                .LOG2_PIX     (LOG2_PIX),
                .MIN_THRES    (MIN_THRES),
                .MAX_THRES    (MAX_THRES),
                .DEFAULT_THRES(DEFAULT_THRES)
            ) u_chan (
                .clk_i   (clk_in),
                .rst_n_i (rst_n_in),
                .pix_i   (px.rgb_in[c*COLOUR_DEPTH +: COLOUR_DEPTH]),
                .seed_i  (seed),
                .add_i   (add),
                .latch_i (latch),
                .clr_i   (clr),
                .thres_o (thres_out[c*COLOUR_DEPTH +: COLOUR_DEPTH]),
                .gt_o    (gt[c])
            );
        end
    endgenerate

    assign pix_ready = !valid_q || px.comp_ready_in;
    assign accept    = px.pix_valid_in && pix_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed    = 1'b0;
        add     = 1'b0;
        latch   = 1'b0;
        clr     = 1'b0;
        emit    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && px.sof_in && px.cfg_enable_in) begin
                    state_d = CALIB;
                    seed    = 1'b1;
                    cnt_d   = LOG2_PIX'(1);
                    emit    = 1'b1;
                end
            end
            CALIB, RUN: begin
                if (accept) begin
                    if (px.sof_in) begin
                        // A new frame always restarts calibration, or parks if disabled.
                        if (px.cfg_enable_in) begin
                            state_d = CALIB;
                            seed    = 1'b1;
                            cnt_d   = LOG2_PIX'(1);
                            emit    = 1'b1;
                        end else begin
                            state_d = IDLE;
                            clr     = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        emit = 1'b1;
                        if (state_q == CALIB) begin
                            if (cnt_q == LAST_PIX) begin
                                latch   = 1'b1;
                                state_d = RUN;
                                cnt_d   = '0;
                                done_d  = 1'b1;
                            end else begin
                                add   = 1'b1;
                                cnt_d = cnt_q + LOG2_PIX'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Output stage: codes use the thresholds held before this edge.
        valid_d = valid_q;
        code_d  = code_q;
        if (emit) begin
            valid_d = 1'b1;
            code_d  = gt;
        end else if (px.comp_ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 3'b000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    assign px.pix_ready_out  = pix_ready;
    assign px.comp_valid_out = valid_q;
    assign px.compressed_out = code_q;
    assign calib_done_out    = done_q;
endmodule

// File: tb/tb_compress_threshold_ctrl.sv
// Directed bench for compress_threshold_ctrl with CALIB_PIXELS=4.
module tb_compress_threshold_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] thres;
    logic        done;
    int          n_pass = 0;
    int          n_total = 0;

    compress_threshold_ctrl_if #(.COLOUR_DEPTH(8)) ifc ();

    compress_threshold_ctrl #(
        .COLOUR_DEPTH(8), .CALIB_PIXELS(4), .MIN_THRES(50),
        .MAX_THRES(200), .DEFAULT_THRES(128)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .px(ifc.slave),
        .thres_out(thres), .calib_done_out(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld, sof, en;
        logic [7:0] r, g, b;
        logic       ev;
        logic [2:0] ec;
        logic       ed;
        logic [23:0] et;
    } vec_t;

    function automatic logic [23:0] pk(input int r, input int g, input int b);
        return {8'(b), 8'(g), 8'(r)};
    endfunction

    function automatic vec_t mk(input logic vld, sof, en, input int r, g, b,
                                input logic ev, input logic [2:0] ec,
                                input logic ed, input logic [23:0] et);
        vec_t v;
        v.vld = vld; v.sof = sof; v.en = en;
        v.r = 8'(r); v.g = 8'(g); v.b = 8'(b);
        v.ev = ev; v.ec = ec; v.ed = ed; v.et = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step(input logic vld, sof, en, rdy, input int r, g, b);
        @(negedge clk);
        ifc.pix_valid_in  = vld;
        ifc.sof_in        = sof;
        ifc.cfg_enable_in = en;
        ifc.comp_ready_in = rdy;
        ifc.rgb_in        = pk(r, g, b);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[18];
    logic [23:0] D, A, B;

    initial begin
        ifc.pix_valid_in = 0; ifc.sof_in = 0; ifc.cfg_enable_in = 0;
        ifc.comp_ready_in = 1; ifc.rgb_in = '0;
        D = pk(128, 128, 128); A = pk(100, 50, 200); B = pk(50, 200, 200);

        tbl[0]  = mk(1, 1, 1, 100, 30, 220, 1, 3'b100, 0, D);
        tbl[1]  = mk(1, 0, 0, 100, 30, 220, 1, 3'b100, 0, D);
        tbl[2]  = mk(1, 0, 0, 100, 30, 220, 1, 3'b100, 0, D);
        tbl[3]  = mk(1, 0, 0, 100, 30, 220, 1, 3'b100, 1, A);
        tbl[4]  = mk(1, 0, 0, 101, 60, 201, 1, 3'b111, 0, A);
        tbl[5]  = mk(1, 0, 0, 100, 50, 200, 1, 3'b000, 0, A);
        tbl[6]  = mk(0, 0, 0,   0,  0,   0, 0, 3'b000, 0, A);
        tbl[7]  = mk(1, 1, 1,  60, 60,  60, 1, 3'b010, 0, A);
        tbl[8]  = mk(1, 0, 0,  60, 60,  60, 1, 3'b010, 0, A);
        tbl[9]  = mk(1, 1, 1,  10, 250, 200, 1, 3'b010, 0, A);
        tbl[10] = mk(1, 0, 0,  10, 250, 200, 1, 3'b010, 0, A);
        tbl[11] = mk(1, 0, 0,  10, 250, 200, 1, 3'b010, 0, A);
        tbl[12] = mk(1, 0, 0,  10, 250, 200, 1, 3'b010, 1, B);
        tbl[13] = mk(1, 0, 0,  50, 201, 200, 1, 3'b010, 0, B);
        tbl[14] = mk(1, 1, 0, 255, 255, 255, 0, 3'b000, 0, B);
        tbl[15] = mk(1, 0, 0, 255, 255, 255, 0, 3'b000, 0, B);
        tbl[16] = mk(1, 0, 1, 255, 255, 255, 0, 3'b000, 0, B);
        tbl[17] = mk(1, 1, 1,  51,   0,   0, 1, 3'b001, 0, B);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ifc.comp_valid_out), 0);
        chk("rst_code",  32'(ifc.compressed_out), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_thres", 32'(thres), 32'(D));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].vld, tbl[i].sof, tbl[i].en, 1'b1, tbl[i].r, tbl[i].g, tbl[i].b);
            chk($sformatf("v%0d_valid", i), 32'(ifc.comp_valid_out), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("v%0d_code", i), 32'(ifc.compressed_out), 32'(tbl[i].ec));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].ed));
            chk($sformatf("v%0d_thres", i), 32'(thres), 32'(tbl[i].et));
        end

        // Backpressure: stalled pixels must not be counted into calibration.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            chk("bp_ready", 32'(ifc.pix_ready_out), 0);
            chk("bp_valid", 32'(ifc.comp_valid_out), 1);
            chk("bp_code",  32'(ifc.compressed_out), 32'(3'b001));
            chk("bp_done",  32'(done), 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 51, 0, 0);
            chk("rel_valid", 32'(ifc.comp_valid_out), 1);
            chk("rel_code",  32'(ifc.compressed_out), 32'(3'b001));
            chk("rel_done",  32'(done), (i == 2) ? 1 : 0);
        end
        chk("rel_thres", 32'(thres), 32'(pk(51, 50, 50)));
        step(0, 0, 0, 1, 0, 0, 0);
        chk("pulse_once", 32'(done), 0);
        chk("drain_valid", 32'(ifc.comp_valid_out), 0);

        // Reset mid-calibration, then recalibrate from scratch.
        step(1, 1, 1, 1, 250, 250, 250);
        chk("pre_rst_code", 32'(ifc.compressed_out), 32'(3'b111));
        step(1, 0, 0, 1, 250, 250, 250);
        @(negedge clk);
        ifc.pix_valid_in = 0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ifc.comp_valid_out), 0);
        chk("mid_rst_code",  32'(ifc.compressed_out), 0);
        chk("mid_rst_done",  32'(done), 0);
        chk("mid_rst_thres", 32'(thres), 32'(D));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1, (i == 0), (i == 0), 1, 120, 120, 120);
            chk("recal_code", 32'(ifc.compressed_out), 0);
            chk("recal_done", 32'(done), (i == 3) ? 1 : 0);
        end
        chk("recal_thres", 32'(thres), 32'(pk(120, 120, 120)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
